// File: rtl/stream_demux_1xn.sv
// One-to-N stream demultiplexer: each word is steered by s_sel into a one-deep
// per-channel output register; out-of-range selects are dropped and counted.
module stream_demux_lane #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          m_ready,
    output logic          full,
    output logic [DW-1:0] data
);
    // Data is zeroed whenever the slot empties, so an idle lane always reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= din;
        end else if (full && m_ready) begin
            full <= 1'b0;
            data <= '0;
        end
    end
endmodule

module stream_demux_1xn #(
    parameter int N_OUT = 4,
    parameter int DW    = 8,
    parameter int SW    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DW-1:0]       s_data,
    input  logic [SW-1:0]       s_sel,
    output logic [N_OUT-1:0]    m_valid,
    input  logic [N_OUT-1:0]    m_ready,
    output logic [N_OUT*DW-1:0] m_data,
    output logic                drop_pulse,
    output logic [7:0]          drop_cnt
);
    if (N_OUT < 2 || N_OUT > 16 || (2 ** SW) < N_OUT) begin : g_bad_params
        $error("stream_demux_1xn: need 2 <= N_OUT <= 16 and 2**SW >= N_OUT");
    end

    logic [N_OUT-1:0] full;
    logic [N_OUT-1:0] sel_hit;
    logic [N_OUT-1:0] load;
    logic             in_range;
    logic             sel_ready;
    logic             drop;

    // s_ready depends only on the selected lane's state, never on s_valid.
    always_comb begin
        sel_hit   = '0;
        in_range  = 1'b0;
        sel_ready = 1'b1;
        for (int k = 0; k < N_OUT; k++) begin
            if (s_sel == SW'(k)) begin
                sel_hit[k] = 1'b1;
                in_range   = 1'b1;
                sel_ready  = !full[k] || m_ready[k];
            end
        end
    end

    assign s_ready = sel_ready;
    assign load    = sel_hit & {N_OUT{s_valid && sel_ready}};
    assign drop    = s_valid && !in_range;
    assign m_valid = full;

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        stream_demux_lane #(.DW(DW)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load[k]),
            .din     (s_data),
            .m_ready (m_ready[k]),
            .full    (full[k]),
            .data    (m_data[k*DW +: DW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            drop_pulse <= drop;
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: doc/stream_demux_1xn.md
STREAM_DEMUX_1XN -- requirements
Module: stream_demux_1xn

Interface
REQ-001 SHALL have parameter N_OUT, default 4, number of output channels, legal range 2..16.
REQ-002 SHALL have parameter DW, default 8, data width in bits.
REQ-003 SHALL have parameter SW, default 2, select width; elaboration SHALL fail unless 2**SW >= N_OUT.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  input word valid.
REQ-007 SHALL have port s_ready  output  1  block accepts input word this cycle.
REQ-008 SHALL have port s_data  input  DW  input word.
REQ-009 SHALL have port s_sel  input  SW  destination channel index.
REQ-010 SHALL have port m_valid  output  N_OUT  per-channel output valid.
REQ-011 SHALL have port m_ready  input  N_OUT  per-channel downstream ready.
REQ-012 SHALL have port m_data  output  N_OUT*DW  channel k at bits [k*DW +: DW].
REQ-013 SHALL have port drop_pulse  output  1  one-cycle pulse per dropped word.
REQ-014 SHALL have port drop_cnt  output  8  saturating count of dropped words.

Function
REQ-015 SHALL hold one output register per channel: full[k] flag plus DW data.
REQ-016 Input transfer SHALL occur on a clk edge where s_valid && s_ready.
REQ-017 s_ready SHALL be combinational from s_sel, full and m_ready only, never from s_valid.
REQ-018 For s_sel < N_OUT: s_ready = !full[s_sel] || m_ready[s_sel].
REQ-019 For s_sel >= N_OUT: s_ready = 1 (drop mode).
REQ-020 Transfer to channel k SHALL load the data register and set full[k]; m_valid[k] = full[k]; latency input-to-m_valid exactly 1 cycle.
REQ-021 Output transfer on channel k (m_valid[k] && m_ready[k]) SHALL clear full[k], unless the same edge loads channel k, then full[k] stays 1 with the new word (1 word/cycle/channel).
REQ-022 While m_valid[k] && !m_ready[k], m_data[k] SHALL remain stable.
REQ-023 When full[k] = 0, m_data[k] SHALL be all zeros; outputs SHALL never carry X.
REQ-024 Non-selected channels SHALL be unaffected by an input transfer; any number of channels MAY drain on the same edge.
REQ-025 Word order within a channel SHALL be preserved.
REQ-026 s_sel and s_data SHALL be sampled only on an input transfer.
REQ-027 Drop-mode transfer SHALL discard the word, assert drop_pulse for exactly the following cycle, and increment drop_cnt, saturating at 255.
REQ-028 Back-to-back drops SHALL hold drop_pulse high for consecutive cycles, one per dropped word.

Reset
REQ-029 rst_n low SHALL immediately clear all full[k], m_valid, m_data, drop_pulse and drop_cnt to 0, independent of clk.
REQ-030 Reset mid-operation SHALL discard held words; no partial output SHALL appear after release.
REQ-031 Release SHALL take effect on the first clk edge with rst_n high; s_ready is then 1 for any s_sel.

Verification
REQ-032 Reset, then s_sel=2, s_data=8'hA5, one cycle s_valid, m_ready=4'hF -> m_valid=4'b0100 and m_data[23:16]=8'hA5 one cycle later; all other lanes 0.
REQ-033 m_ready[1]=0, send 8'h11 then 8'h22 to channel 1 -> first accepted, s_ready=0 for second until m_ready[1]=1; then 8'h11 out, 8'h22 loaded on the same edge, no bubble.
REQ-034 Channel 0 full and stalled, word to channel 3 -> accepted immediately, m_valid=4'b1001, channel 0 data unchanged.
REQ-035 N_OUT=3, SW=2, s_sel=3, 300 consecutive valid words -> s_ready stays 1, no m_valid, drop_pulse high 300 cycles, drop_cnt=255.
REQ-036 Channels 0 and 2 full, rst_n low mid-cycle -> m_valid=0, m_data=0 before next clk edge; after release no stale word emitted.
REQ-037 Random s_sel/m_ready, 10k words, N_OUT=4, DW=16 -> per-channel scoreboard matches in order, zero loss, no X on outputs.
